clk_div_bank: RTL

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank_pkg.sv | 26 ++
 rtl/clk_div_bank_if.sv | 38 +++
 rtl/clk_div_chan.sv | 107 ++++++++++
 rtl/clk_div_defs.vh | 11 +
 rtl/clk_div_bank.sv | 55 +++++
 5 files changed

// File: rtl/clk_div_bank_pkg.sv
// ============================================================================
// clk_div_bank_pkg : shared constants, types and helpers for clk_div_bank
// Revision         : 1.0
// ============================================================================
`include "clk_div_defs.vh"
`default_nettype none

package clk_div_bank_pkg;

   localparam int C_DEF_DIV = `CLK_DIV_DEF_DIV;
   localparam int C_MAX_CH  = `CLK_DIV_MAX_CH;

   // What a channel does on the coming edge.
   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_WRAP = 2'd1,
      CH_RUN  = 2'd2
   } ch_mode_e;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_bank_if.sv
// ============================================================================
// clk_div_bank_if : control/config and output bundle of the divider bank
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface clk_div_bank_if
   import clk_div_bank_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int DIV_W = 8
) ();

   localparam int CH_W = ch_width(N_CH);

   logic [N_CH-1:0]  en;
   logic             sync;
   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [DIV_W-1:0] wr_div;
   logic [DIV_W-1:0] wr_high;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  pending;

   modport master (
      output en, sync, wr_en, wr_ch, wr_div, wr_high,
      input  clk_out, tick, pending
   );

   modport slave (
      input  en, sync, wr_en, wr_ch, wr_div, wr_high,
      output clk_out, tick, pending
   );

endinterface

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// clk_div_chan : one programmable divider channel with shadowed, glitch-free retune
// Revision     : 1.0
// ============================================================================
`default_nettype none

module clk_div_chan
   import clk_div_bank_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = C_DEF_DIV
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             en,
   input  wire logic             sync,
   input  wire logic             wr,
   input  wire logic [DIV_W-1:0] wr_div,
   input  wire logic [DIV_W-1:0] wr_high,
   output logic                  clk_out,
   output logic                  tick,
   output logic                  pending
);

   localparam logic [DIV_W-1:0] C_RST_D   = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] C_RST_H   = DIV_W'(DEF_DIV >> 1);
   localparam logic [DIV_W-1:0] C_RST_CNT = DIV_W'(DEF_DIV - 1);

   logic [DIV_W-1:0] r_sh_d, r_sh_h, r_act_d, r_act_h, r_cnt;
   logic             r_clk_out, r_tick, r_pending;

   logic [DIV_W-1:0] w_eff_d, w_eff_h, w_cnt_n;
   logic             w_load, w_clk_n, w_tick_n, w_pending_n;
   ch_mode_e         w_mode;

   always_comb begin
      w_eff_d     = wr ? wr_div  : r_sh_d;
      w_eff_h     = wr ? wr_high : r_sh_h;
      w_load      = 1'b0;
      w_cnt_n     = r_cnt;
      w_clk_n     = 1'b0;
      w_tick_n    = 1'b0;

      // Sync and a stopped channel (D=0) are treated as a period boundary.
      if (!en)
         w_mode = CH_IDLE;
      else if (sync || (r_act_d == '0) || (r_cnt == r_act_d - 1'b1))
         w_mode = CH_WRAP;
      else
         w_mode = CH_RUN;

      case (w_mode)
         CH_IDLE: begin
            w_load  = 1'b1;
            w_cnt_n = (w_eff_d == '0) ? '0 : w_eff_d - 1'b1;
         end
         CH_WRAP: begin
            w_load   = 1'b1;
            w_cnt_n  = '0;
            w_tick_n = (w_eff_d != '0);
            w_clk_n  = (w_eff_d != '0) && (w_eff_h != '0);
         end
         default: begin
            w_cnt_n = r_cnt + 1'b1;
            w_clk_n = (w_cnt_n < r_act_h);
         end
      endcase

      if (w_load)
         w_pending_n = 1'b0;
      else
         w_pending_n = wr | r_pending;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_d    <= C_RST_D;
         r_sh_h    <= C_RST_H;
         r_act_d   <= C_RST_D;
         r_act_h   <= C_RST_H;
         r_cnt     <= C_RST_CNT;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (wr) begin
            r_sh_d <= wr_div;
            r_sh_h <= wr_high;
         end
         if (w_load) begin
            r_act_d <= w_eff_d;
            r_act_h <= w_eff_h;
         end
         r_cnt     <= w_cnt_n;
         r_clk_out <= w_clk_n;
         r_tick    <= w_tick_n;
         r_pending <= w_pending_n;
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;
   assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/clk_div_defs.vh
// ============================================================================
// clk_div_defs : shared default constants for the clock-divider bank
// Revision     : 1.0
// ============================================================================
`ifndef CLK_DIV_DEFS_VH
`define CLK_DIV_DEFS_VH

`define CLK_DIV_DEF_DIV 4
`define CLK_DIV_MAX_CH  16

`endif

// File: rtl/clk_div_bank.sv
// ============================================================================
// clk_div_bank : bank of N_CH independent programmable clock dividers
// Revision     : 1.0
// ============================================================================
`default_nettype none

module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = C_DEF_DIV
) (
   input  wire logic     clk,
   input  wire logic     rst,
   clk_div_bank_if.slave bus
);

   localparam int CH_W = ch_width(N_CH);

   logic            w_ch_ok;
   logic [N_CH-1:0] w_wr, w_clk_out, w_tick, w_pending;

   // Out-of-range channel numbers are dropped rather than aliased.
   assign w_ch_ok = (32'(bus.wr_ch) < N_CH);

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_chan
         assign w_wr[i] = bus.wr_en && w_ch_ok && (bus.wr_ch == CH_W'(i));

         clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en[i]),
            .sync    (bus.sync),
            .wr      (w_wr[i]),
            .wr_div  (bus.wr_div),
            .wr_high (bus.wr_high),
            .clk_out (w_clk_out[i]),
            .tick    (w_tick[i]),
            .pending (w_pending[i])
         );
      end
   endgenerate

   assign bus.clk_out = w_clk_out;
   assign bus.tick    = w_tick;
   assign bus.pending = w_pending;

endmodule

`default_nettype wire
